pixel_job_scheduler: RTL

PIXEL_JOB_SCHEDULER -- requirements
Module: pixel_job_scheduler

---
 rtl/fractal_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/pixel_job_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fractal_pkg.sv
// rtl/fractal_pkg.sv - shared frame geometry, field widths and reorder slot states
package fractal_pkg;

    localparam int X_SIZE_DEF = 640;
    localparam int Y_SIZE_DEF = 480;
    localparam int X_W        = 10;
    localparam int Y_W        = 9;
    localparam int ITER_W     = 8;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_DONE    = 2'd2
    } slot_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant; priority restarts after the last accepted engine
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [N-1:0] req,
    input  logic [N-1:0] accept,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;

    // Scan downward so the request closest to ptr overwrites any farther one.
    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                grant = N'(1) << idx;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (accept[i]) begin
                    ptr <= PW'((i + 1) % N);
                end
            end
        end
    end

endmodule

// File: rtl/pixel_job_scheduler.sv
// rtl/pixel_job_scheduler.sv - issues raster pixel jobs to iteration engines and re-orders their results
module pixel_job_scheduler
    import fractal_pkg::*;
#(
    parameter int N_ENG  = 4,
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    enable,
    output logic [N_ENG-1:0]        job_valid,
    input  logic [N_ENG-1:0]        job_ready,
    output logic [X_W-1:0]          job_x,
    output logic [Y_W-1:0]          job_y,
    input  logic [N_ENG-1:0]        res_valid,
    input  logic [ITER_W*N_ENG-1:0] res_iter,
    output logic [N_ENG-1:0]        res_ready,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [ITER_W-1:0]       pix_iter,
    output logic                    pix_sof,
    output logic                    pix_eol,
    output logic                    busy,
    output logic [15:0]             frame_count
);

    localparam int SW = $clog2(N_ENG);

    slot_state_t       slot_state [N_ENG];
    logic [ITER_W-1:0] slot_iter  [N_ENG];
    logic [SW-1:0]     eng_slot   [N_ENG];
    logic [N_ENG-1:0]  eng_pend;
    logic [SW-1:0]     issue_slot;
    logic [SW-1:0]     emit_slot;
    logic [X_W-1:0]    emit_x;
    logic [Y_W-1:0]    emit_y;
    logic [N_ENG-1:0]  grant;
    logic [N_ENG-1:0]  job_xfer;
    logic [N_ENG-1:0]  res_xfer;
    logic              issue_ok;
    logic              pix_xfer;
    logic              emit_last;

    assign job_xfer  = job_valid & job_ready;
    assign res_ready = eng_pend;
    assign res_xfer  = res_valid & eng_pend;

    // The cycle after a transfer is left empty so the offer is always rebuilt from settled slot state.
    assign issue_ok  = enable && (slot_state[issue_slot] == SLOT_FREE) && (job_xfer == '0);

    assign pix_valid = (slot_state[emit_slot] == SLOT_DONE);
    assign pix_xfer  = pix_valid && pix_ready;
    assign pix_iter  = pix_valid ? slot_iter[emit_slot] : '0;
    assign pix_sof   = pix_valid && (emit_x == '0) && (emit_y == '0);
    assign pix_eol   = pix_valid && (emit_x == X_W'(X_SIZE - 1));
    assign emit_last = (emit_x == X_W'(X_SIZE - 1)) && (emit_y == Y_W'(Y_SIZE - 1));

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N_ENG; i++) begin
            if (slot_state[i] != SLOT_FREE) begin
                busy = 1'b1;
            end
        end
    end

    rr_arbiter #(.N(N_ENG)) u_rr_arbiter (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (job_ready & ~eng_pend),
        .accept  (job_xfer),
        .grant   (grant)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            job_valid   <= '0;
            job_x       <= '0;
            job_y       <= '0;
            emit_x      <= '0;
            emit_y      <= '0;
            issue_slot  <= '0;
            emit_slot   <= '0;
            eng_pend    <= '0;
            frame_count <= '0;
            for (int i = 0; i < N_ENG; i++) begin
                slot_state[i] <= SLOT_FREE;
                slot_iter[i]  <= '0;
                eng_slot[i]   <= '0;
            end
        end else begin
            job_valid <= issue_ok ? grant : '0;

            if (job_xfer != '0) begin
                slot_state[issue_slot] <= SLOT_PENDING;
                for (int k = 0; k < N_ENG; k++) begin
                    if (job_xfer[k]) begin
                        eng_pend[k] <= 1'b1;
                        eng_slot[k] <= issue_slot;
                    end
                end
                issue_slot <= (issue_slot == SW'(N_ENG - 1)) ? '0 : issue_slot + 1'b1;
                if (job_x == X_W'(X_SIZE - 1)) begin
                    job_x <= '0;
                    job_y <= (job_y == Y_W'(Y_SIZE - 1)) ? '0 : job_y + 1'b1;
                end else begin
                    job_x <= job_x + 1'b1;
                end
            end

            // Every pending engine owns a distinct slot, so simultaneous returns never collide.
            for (int k = 0; k < N_ENG; k++) begin
                if (res_xfer[k]) begin
                    slot_state[eng_slot[k]] <= SLOT_DONE;
                    slot_iter[eng_slot[k]]  <= res_iter[ITER_W*k +: ITER_W];
                    eng_pend[k]             <= 1'b0;
                end
            end

            if (pix_xfer) begin
                slot_state[emit_slot] <= SLOT_FREE;
                emit_slot <= (emit_slot == SW'(N_ENG - 1)) ? '0 : emit_slot + 1'b1;
                if (emit_x == X_W'(X_SIZE - 1)) begin
                    emit_x <= '0;
                    emit_y <= (emit_y == Y_W'(Y_SIZE - 1)) ? '0 : emit_y + 1'b1;
                end else begin
                    emit_x <= emit_x + 1'b1;
                end
                if (emit_last) begin
                    frame_count <= frame_count + 1'b1;
                end
            end
        end
    end

endmodule
